// File: rtl/ls_access_stage.sv
// Local-store access stage of the SPU odd pipe: owns the 2048 x 128-bit local store,
// commits stores in the issue cycle and returns loads after a fixed LAT-cycle pipeline.
module ls_access_stage #(
    parameter int         LAT      = 6,
    parameter int         QW_DEPTH = 2048,
    // Decoder encodings of the instr_ID_* constants; override to match the decoder.
    parameter logic [0:6] ID_LQA   = 7'h01,
    parameter logic [0:6] ID_LQD   = 7'h02,
    parameter logic [0:6] ID_STQA  = 7'h03,
    parameter logic [0:6] ID_STQD  = 7'h04
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_issue_valid,
    input  logic [0:6]   i_instr_id,
    input  logic [0:14]  i_addr,
    input  logic [0:127] i_st_data,
    input  logic [0:6]   i_rt_addr,
    input  logic         i_flush,
    output logic         o_rd_valid,
    output logic [0:127] o_rd_data,
    output logic [0:6]   o_rd_rt,
    output logic         o_busy
);
    localparam int AW = $clog2(QW_DEPTH);

    logic [0:127]         r_mem [QW_DEPTH];
    logic [LAT:1]         r_vld_pipe;
    logic [LAT:1][0:127]  r_data;
    logic [LAT:1][0:6]    r_rt;

    logic          w_acc;
    logic          w_ld;
    logic          w_st;
    logic [AW-1:0] w_idx;

    // Reset and flush both veto the issue, so neither a store nor a load can slip through.
    assign w_acc = i_reset & i_issue_valid & ~i_flush;
    assign w_ld  = w_acc & ((i_instr_id == ID_LQA)  | (i_instr_id == ID_LQD));
    assign w_st  = w_acc & ((i_instr_id == ID_STQA) | (i_instr_id == ID_STQD));
    assign w_idx = i_addr[0:AW-1];

    always_ff @(posedge i_clk) begin
        if (w_st)
            r_mem[w_idx] <= i_st_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_vld_pipe <= '0;
            r_data     <= '0;
            r_rt       <= '0;
        end else if (i_flush) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[LAT-1:1], w_ld};
            if (w_ld) begin
                r_data[1] <= r_mem[w_idx];
                r_rt[1]   <= i_rt_addr;
            end
            // Data only moves with a valid entry so the output holds between results.
            for (int k = 2; k <= LAT; k++) begin
                if (r_vld_pipe[k-1]) begin
                    r_data[k] <= r_data[k-1];
                    r_rt[k]   <= r_rt[k-1];
                end
            end
        end
    end

    assign o_rd_valid = r_vld_pipe[LAT];
    assign o_rd_data  = r_data[LAT];
    assign o_rd_rt    = r_rt[LAT];
    assign o_busy     = |r_vld_pipe;
endmodule

// File: tb/tb_ls_access_stage.sv
// Bench for ls_access_stage: three instances (LAT 6/2/8) share one stimulus stream and
// are checked each cycle against a queue-based model plus a few literal expectations.
module tb_ls_access_stage;
    localparam logic [0:6] LQA  = 7'h01;
    localparam logic [0:6] LQD  = 7'h02;
    localparam logic [0:6] STQA = 7'h03;
    localparam logic [0:6] STQD = 7'h04;
    localparam logic [0:6] NOOP = 7'h7F;
    localparam int LATS [3] = '{6, 2, 8};
    localparam logic [0:127] P = 128'hDEADBEEF_00000000_CAFEF00D_12345678;

    logic         clk = 0;
    logic         reset, issue_valid, flush;
    logic [0:6]   instr_id, rt_addr;
    logic [0:14]  addr;
    logic [0:127] st_data;
    logic         rv [3];
    logic [0:127] rd [3];
    logic [0:6]   rr [3];
    logic         bz [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ls_access_stage #(.LAT(LATS[g]), .QW_DEPTH(2048),
                          .ID_LQA(LQA), .ID_LQD(LQD), .ID_STQA(STQA), .ID_STQD(STQD)) u_dut (
            .i_clk(clk), .i_reset(reset), .i_issue_valid(issue_valid), .i_instr_id(instr_id),
            .i_addr(addr), .i_st_data(st_data), .i_rt_addr(rt_addr), .i_flush(flush),
            .o_rd_valid(rv[g]), .o_rd_data(rd[g]), .o_rd_rt(rr[g]), .o_busy(bz[g]));
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input bit ok, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int           due;
        int           j;
        logic [0:127] d;
        logic [0:6]   rt;
        bit           known;
    } pend_t;

    pend_t        pq [$];
    logic [0:127] mmem   [2048];
    bit           mknown [2048];
    logic [0:127] last_d [3];
    logic [0:6]   last_rt [3];
    bit           last_known [3];
    int           cyc = 0;
    bit           chk_en = 0;

    function automatic bit is_ld(input logic [0:6] id);
        return id == LQA || id == LQD;
    endfunction
    function automatic bit is_st(input logic [0:6] id);
        return id == STQA || id == STQD;
    endfunction

    // Cycle c ends at this edge: apply the instruction presented during cycle c.
    always @(posedge clk) begin
        int c;
        int qi;
        c  = cyc;
        qi = int'(addr[0:10]);
        if (!reset || flush) begin
            for (int i = pq.size() - 1; i >= 0; i--)
                if (pq[i].due > c) pq.delete(i);
        end
        if (!reset) begin
            chk_en = 1;
            for (int j = 0; j < 3; j++) begin
                last_d[j] = '0; last_rt[j] = '0; last_known[j] = 1;
            end
        end else if (issue_valid && !flush) begin
            if (is_st(instr_id)) begin
                mmem[qi] = st_data; mknown[qi] = 1;
            end else if (is_ld(instr_id)) begin
                for (int j = 0; j < 3; j++)
                    pq.push_back('{due: c + LATS[j], j: j, d: mmem[qi], rt: rt_addr, known: mknown[qi]});
            end
        end
        cyc = c + 1;
    end

    // Compare all instances against the model in the middle of every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 3; j++) begin
                bit ev, eb;
                int hit;
                ev = 0; eb = 0; hit = -1;
                foreach (pq[i]) begin
                    if (pq[i].j == j && pq[i].due == cyc) begin ev = 1; hit = i; end
                    if (pq[i].j == j && pq[i].due >= cyc) eb = 1;
                end
                chk($sformatf("rd_valid L%0d c%0d", LATS[j], cyc), rv[j] === ev, 128'(rv[j]), 128'(ev));
                chk($sformatf("busy L%0d c%0d", LATS[j], cyc), bz[j] === eb, 128'(bz[j]), 128'(eb));
                if (ev) begin
                    last_d[j] = pq[hit].d; last_rt[j] = pq[hit].rt; last_known[j] = pq[hit].known;
                end
                chk($sformatf("rd_rt L%0d c%0d", LATS[j], cyc), rr[j] === last_rt[j], 128'(rr[j]), 128'(last_rt[j]));
                if (last_known[j])
                    chk($sformatf("rd_data L%0d c%0d", LATS[j], cyc), rd[j] === last_d[j], rd[j], last_d[j]);
            end
            for (int i = pq.size() - 1; i >= 0; i--)
                if (pq[i].due <= cyc) pq.delete(i);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic [0:6] id, input logic [0:14] a,
                         input logic [0:127] d, input logic [0:6] rt, input bit fl, input bit rs);
        issue_valid = v; instr_id = id; addr = a; st_data = d; rt_addr = rt;
        flush = fl; reset = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, NOOP, '0, '0, '0, 0, 1);
    endtask

    function automatic logic [0:127] pat(input int i);
        return {4{32'hA5000000 + 32'(i)}};
    endfunction

    initial begin
        int pulses;
        reset = 0; issue_valid = 0; flush = 0; instr_id = NOOP; addr = '0; st_data = '0; rt_addr = '0;
        #1;
        // Reset held with a store presented: nothing may commit.
        for (int i = 0; i < 3; i++) drive(1, STQA, 15'h0120, P, 7'd0, 0, 0);
        chk("reset rd_valid", rv[0] === 1'b0, 128'(rv[0]), 128'd0);
        chk("reset rd_data", rd[0] === '0, rd[0], '0);
        chk("reset rd_rt", rr[0] === 7'd0, 128'(rr[0]), 128'd0);
        chk("reset busy", bz[0] === 1'b0, 128'(bz[0]), 128'd0);
        drive(1, LQD, 15'h0120, '0, 7'd3, 0, 1);
        for (int i = 0; i < 5; i++) idle();
        chk("reset load valid", rv[0] === 1'b1, 128'(rv[0]), 128'd1);
        chk("reset store differs", rd[0] !== P, rd[0], P);

        // Store then load, literal timing for all three latencies.
        drive(1, STQA, 15'h0120, P, 7'd0, 0, 1);
        drive(1, LQD, 15'h012F, '0, 7'd5, 0, 1);
        idle();
        chk("L2 valid", rv[1] === 1'b1, 128'(rv[1]), 128'd1);
        chk("L2 data", rd[1] === P, rd[1], P);
        for (int i = 0; i < 3; i++) idle();
        chk("L6 early", rv[0] === 1'b0, 128'(rv[0]), 128'd0);
        idle();
        chk("L6 valid", rv[0] === 1'b1, 128'(rv[0]), 128'd1);
        chk("L6 rt", rr[0] === 7'd5, 128'(rr[0]), 128'd5);
        chk("L6 data", rd[0] === P, rd[0], P);
        idle(); idle();
        chk("L8 valid", rv[2] === 1'b1, 128'(rv[2]), 128'd1);
        chk("L8 data", rd[2] === P, rd[2], P);
        for (int i = 0; i < 4; i++) idle();

        // Pipelined loads of quadwords 0..7.
        for (int i = 0; i < 8; i++) drive(1, STQD, 15'(i * 16), pat(i), 7'd0, 0, 1);
        for (int t = 1; t <= 15; t++) begin
            if (t <= 8) drive(1, LQA, 15'((t - 1) * 16 + 3), '0, 7'(9 + t), 0, 1);
            else idle();
            if (t >= 6 && t <= 13) begin
                chk($sformatf("pipe rt t%0d", t), rv[0] === 1'b1 && rr[0] === 7'(4 + t), 128'(rr[0]), 128'(4 + t));
                chk($sformatf("pipe data t%0d", t), rd[0] === pat(t - 6), rd[0], pat(t - 6));
            end
            if (t == 13) chk("pipe busy last", bz[0] === 1'b1, 128'(bz[0]), 128'd1);
            if (t == 14) chk("pipe busy fall", bz[0] === 1'b0, 128'(bz[0]), 128'd0);
        end

        // Flush kills three in-flight loads and a store presented with it.
        for (int i = 0; i < 3; i++) drive(1, LQD, 15'(i * 16), '0, 7'(30 + i), 0, 1);
        drive(1, STQD, 15'h0000, ~P, 7'd0, 1, 1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            pulses += int'(rv[0]) + int'(rv[1]) + int'(rv[2]);
        end
        chk("flush pulses", pulses == 0, 128'(pulses), 128'd0);
        drive(1, LQA, 15'h0000, '0, 7'd20, 0, 1);
        for (int i = 0; i < 5; i++) idle();
        chk("flush store dropped", rd[0] === pat(0), rd[0], pat(0));

        // Non-LS ID on a stored address: no write, no result.
        drive(1, NOOP, 15'h0010, ~P, 7'd21, 0, 1);
        drive(1, LQA, 15'h0010, '0, 7'd22, 0, 1);
        for (int i = 0; i < 5; i++) idle();
        chk("noop mem kept", rd[0] === pat(1), rd[0], pat(1));
        chk("noop rt", rr[0] === 7'd22, 128'(rr[0]), 128'd22);

        // Randomized traffic, including flushes and resets.
        for (int i = 0; i < 800; i++) begin
            logic [0:6] ids [5];
            logic [0:127] d;
            ids = '{LQA, LQD, STQA, STQD, NOOP};
            d = {$urandom, $urandom, $urandom, $urandom};
            drive($urandom_range(0, 3) != 0, ids[$urandom_range(0, 4)],
                  15'($urandom_range(0, 15) * 16 + $urandom_range(0, 15)), d,
                  7'($urandom_range(0, 127)), $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
        end
        for (int i = 0; i < 12; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
